rsju_instruction_encoder: RTL and testbench
===========================================

// Module: rsju_instruction_encoder
// PURPOSE
//  Inverse of the RSJU mnemonic decoder. Accepts a 5-char space-padded ASCII mnemonic
//  serially, one byte per handshake, plus a parallel operand bundle. Emits the 32-bit
//  RV32I word for the R/S/J/U subset. Feeds the instruction memory loader and test benches.
// PARAMETERS
//  MNEM_LEN   5  chars per mnemonic; fixed, first char = leftmost
//  ERR_CNT_W  8  width of saturating unknown-mnemonic counter
// PORTS
//  clock       in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high; clears all state
//  char_in     in   8          ASCII mnemonic byte
//  char_valid  in   1          char_in valid
//  char_ready  out  1          encoder can accept a char
//  rd/rs1/rs2  in   5 each     register operands, sampled with char 1
//  imm         in   32         immediate, sampled with char 1 (S: imm[11:0], J: imm[20:1], U: imm[31:12])
//  instr_out   out  32         encoded instruction
//  instr_valid out  1          instr_out valid; held until accepted
//  instr_ready in   1          downstream accepts instr_out
//  err         out  1          1-cycle pulse: unknown mnemonic or funct3 slot
//  err_count   out  ERR_CNT_W  saturating count of err pulses
// BEHAVIOUR
//  Reset: state IDLE, char_ready=1, instr_out=0, instr_valid=0, err=0, err_count=0, idx=0.
//  Handshakes: a transfer happens on an edge with valid&&ready. Both sides use the same rule.
//  FSM:
//   IDLE    char xfer -> store char[0]; latch rd/rs1/rs2/imm; go to COLLECT (idx=1).
//   COLLECT each xfer stores char[idx]; idx++. The 5th char -> ENCODE.
//   ENCODE  one cycle, char_ready=0. Known mnemonic -> register instr_out, instr_valid=1,
//           go to OUT. Unknown -> err=1 for one cycle, err_count++ (saturating at all-ones),
//           instr_out unchanged, go to IDLE.
//   OUT     hold instr_out/instr_valid stable until instr_ready. Then instr_valid=0, go to IDLE.
//  char_ready=1 only in IDLE/COLLECT. There is no bypass: no char accepted in the OUT exit cycle.
//  Latency: instr_valid rises on the edge after the edge that accepts char 5.
//  Gaps in char_valid stall COLLECT indefinitely. Operands are not resampled.
//  Encodings, with fields {f7,rs2,rs1,f3,rd,op}:
//   R  op=0110011. ADD/SUB f3=0; SLL 1; SLT 2; SLTU 3; XOR 4; SRL/SRA 5; OR 6; AND 7.
//      f7=7'h20 for SUB/SRA, else 7'h00.
//   S  op=0100011; {imm[11:5],rs2,rs1,f3,imm[4:0],op}. SB f3=0; SH 1; SW 2.
//   J  JAL op=1101111; {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//   U  LUI op=0110111, AUIPC op=0010111; {imm[31:12],rd,op}.
//  Mnemonic match is exact 40-bit compare incl. trailing spaces ("OR   ", "AUIPC").
//  Unused imm bits are ignored. imm[0] for J is ignored.
//  Reset mid-operation (any state): immediate return to reset values; partial mnemonic discarded.
// CONFIGURATION
//  RSJU_LOWERCASE_EN defined: each incoming byte in 'a'..'z' is folded to uppercase
//  before storage, so "add  " encodes as ADD.
//  Not defined: bytes are stored raw; lowercase mnemonics produce err.
// STRUCTURE
//  Shared package rsju_pkg: opcode constants (OP_R, OP_S, OP_JAL, OP_LUI, OP_AUIPC),
//  funct3/funct7 constants, 40-bit mnemonic string constants, FSM state typedef.
//  The same package serves the decoder.
//  One sub-module: rsju_mnem_lookup. Combinational map from 40-bit mnemonic to
//  {known, fmt, f3, f7, op}. The FSM/assembly logic stays in the top.
// TESTING
//  1 "ADD  ", rd=3 rs1=1 rs2=2 -> instr_out=0x002081B3, valid 1 cycle after char 5.
//  2 "SUB  ", rd=5 rs1=6 rs2=7 -> 0x407302B3. "SW   ", rs1=1 rs2=2 imm=8 -> 0x0020A423.
//  3 "LUI  ", rd=5 imm=0x12345000 -> 0x123452B7. "JAL  ", rd=1 imm=8 -> 0x008000EF.
//  4 instr_ready held 0 for 10 cycles -> instr_out stable, char_ready=0. Release -> one xfer,
//    then IDLE.
//  5 "FOO  " -> err pulse, err_count=1, no instr_valid. 260 bad mnemonics -> err_count=255.
//  6 reset after char 3 -> all outputs 0. A fresh "OR   " rd=1 rs1=2 rs2=3 -> 0x003160B3.
//    "add  " -> err without the macro, 0x002081B3 with it.

Source files
------------

// File: rtl/rsju_pkg.sv
// Shared RSJU definitions: opcodes, funct fields, mnemonic strings, FSM state.
// Used by both the mnemonic encoder and the decoder.
package rsju_pkg;

    localparam int MNEM_LEN = 5;
    localparam logic [2:0] LAST_IDX = 3'(MNEM_LEN - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;
    localparam logic [2:0] F3_SW   = 3'd2;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // First character sits in the most significant byte.
    localparam logic [39:0] M_ADD   = "ADD  ";
    localparam logic [39:0] M_SUB   = "SUB  ";
    localparam logic [39:0] M_SLL   = "SLL  ";
    localparam logic [39:0] M_SLT   = "SLT  ";
    localparam logic [39:0] M_SLTU  = "SLTU ";
    localparam logic [39:0] M_XOR   = "XOR  ";
    localparam logic [39:0] M_SRL   = "SRL  ";
    localparam logic [39:0] M_SRA   = "SRA  ";
    localparam logic [39:0] M_OR    = "OR   ";
    localparam logic [39:0] M_AND   = "AND  ";
    localparam logic [39:0] M_SB    = "SB   ";
    localparam logic [39:0] M_SH    = "SH   ";
    localparam logic [39:0] M_SW    = "SW   ";
    localparam logic [39:0] M_JAL   = "JAL  ";
    localparam logic [39:0] M_LUI   = "LUI  ";
    localparam logic [39:0] M_AUIPC = "AUIPC";

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_ENCODE, ST_OUT} state_t;
    typedef enum logic [1:0] {FMT_R, FMT_S, FMT_J, FMT_U} fmt_t;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        return c;
    endfunction

endpackage

// File: rtl/rsju_instruction_encoder_if.sv
// Character/operand input stream and encoded-instruction output stream of the encoder.
interface rsju_instruction_encoder_if;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output char_in, char_valid, rd, rs1, rs2, imm, instr_ready,
        input  char_ready, instr_out, instr_valid
    );
    modport slave (
        input  char_in, char_valid, rd, rs1, rs2, imm, instr_ready,
        output char_ready, instr_out, instr_valid
    );
endinterface

// File: rtl/rsju_mnem_lookup.sv
// Combinational map from a 40-bit space-padded mnemonic to its encoding fields.
module rsju_mnem_lookup
    import rsju_pkg::*;
(
    input  logic [39:0] mnem,
    output logic        known,
    output fmt_t        fmt,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [6:0]  op
);
    always_comb begin
        known = 1'b1;
        fmt   = FMT_R;
        f3    = 3'd0;
        f7    = F7_BASE;
        op    = OP_R;
        case (mnem)
            M_ADD:   f3 = F3_ADD;
            M_SUB:   begin f3 = F3_ADD; f7 = F7_ALT; end
            M_SLL:   f3 = F3_SLL;
            M_SLT:   f3 = F3_SLT;
            M_SLTU:  f3 = F3_SLTU;
            M_XOR:   f3 = F3_XOR;
            M_SRL:   f3 = F3_SRL;
            M_SRA:   begin f3 = F3_SRL; f7 = F7_ALT; end
            M_OR:    f3 = F3_OR;
            M_AND:   f3 = F3_AND;
            M_SB:    begin fmt = FMT_S; op = OP_S; f3 = F3_SB; end
            M_SH:    begin fmt = FMT_S; op = OP_S; f3 = F3_SH; end
            M_SW:    begin fmt = FMT_S; op = OP_S; f3 = F3_SW; end
            M_JAL:   begin fmt = FMT_J; op = OP_JAL; end
            M_LUI:   begin fmt = FMT_U; op = OP_LUI; end
            M_AUIPC: begin fmt = FMT_U; op = OP_AUIPC; end
            default: known = 1'b0;
        endcase
    end
endmodule

// File: rtl/rsju_instruction_encoder.sv
// Serial ASCII mnemonic + operand bundle -> RV32I word (R/S/J/U subset).
// Define RSJU_LOWERCASE_EN to fold 'a'..'z' to uppercase before storage.
module rsju_instruction_encoder
    import rsju_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    rsju_instruction_encoder_if.slave bus,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);
    state_t                state_reg;
    logic [2:0]            idx_reg;
    logic [39:0]           mnem_reg;
    logic [4:0]            rd_reg, rs1_reg, rs2_reg;
    logic [31:0]           imm_reg;
    logic                  char_ready_reg;
    logic [31:0]           instr_out_reg;
    logic                  instr_valid_reg;
    logic                  err_reg;
    logic [ERR_CNT_W-1:0]  err_count_reg;

    logic [7:0]  char_byte;
    logic        xfer;
    logic        known;
    fmt_t        fmt;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [31:0] instr_next;

`ifdef RSJU_LOWERCASE_EN
    assign char_byte = to_upper(bus.char_in);
`else
    assign char_byte = bus.char_in;
`endif

    assign xfer = bus.char_valid && char_ready_reg;

    rsju_mnem_lookup u_lookup (
        .mnem  (mnem_reg),
        .known (known),
        .fmt   (fmt),
        .f3    (f3),
        .f7    (f7),
        .op    (op)
    );

    always_comb begin
        instr_next = '0;
        case (fmt)
            FMT_R: instr_next = {f7, rs2_reg, rs1_reg, f3, rd_reg, op};
            FMT_S: instr_next = {imm_reg[11:5], rs2_reg, rs1_reg, f3, imm_reg[4:0], op};
            FMT_J: instr_next = {imm_reg[20], imm_reg[10:1], imm_reg[11], imm_reg[19:12], rd_reg, op};
            FMT_U: instr_next = {imm_reg[31:12], rd_reg, op};
            default: instr_next = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= 3'd0;
            mnem_reg        <= '0;
            rd_reg          <= '0;
            rs1_reg         <= '0;
            rs2_reg         <= '0;
            imm_reg         <= '0;
            char_ready_reg  <= 1'b1;
            instr_out_reg   <= '0;
            instr_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (xfer) begin
                        // Operands are captured only with the first character.
                        mnem_reg  <= {mnem_reg[31:0], char_byte};
                        rd_reg    <= bus.rd;
                        rs1_reg   <= bus.rs1;
                        rs2_reg   <= bus.rs2;
                        imm_reg   <= bus.imm;
                        idx_reg   <= 3'd1;
                        state_reg <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (xfer) begin
                        mnem_reg <= {mnem_reg[31:0], char_byte};
                        if (idx_reg == LAST_IDX) begin
                            idx_reg        <= 3'd0;
                            char_ready_reg <= 1'b0;
                            state_reg      <= ST_ENCODE;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                ST_ENCODE: begin
                    if (known) begin
                        instr_out_reg   <= instr_next;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ST_OUT;
                    end else begin
                        err_reg <= 1'b1;
                        if (err_count_reg != '1)
                            err_count_reg <= err_count_reg + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        char_ready_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    // char_ready only rises after the handoff, so no char slips in this cycle.
                    if (bus.instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        char_ready_reg  <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.char_ready  = char_ready_reg;
    assign bus.instr_out   = instr_out_reg;
    assign bus.instr_valid = instr_valid_reg;
    assign err             = err_reg;
    assign err_count       = err_count_reg;

endmodule

// File: tb/tb_rsju_instruction_encoder.sv
// Directed table-driven bench for rsju_instruction_encoder plus stall, saturation and reset sequences.
module tb_rsju_instruction_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       err;
    logic [7:0] err_count;

    rsju_instruction_encoder_if ifc ();

    rsju_instruction_encoder #(.ERR_CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (ifc),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] mnem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        exp_err;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[14];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        ifc.char_in    = c;
        ifc.char_valid = 1'b1;
        while (!ifc.char_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL char_ready_timeout: got 0 expected 1");
        end
        @(negedge clock);
        ifc.char_valid = 1'b0;
    endtask

    task automatic send_mnem(input logic [39:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                ifc.rd = rd; ifc.rs1 = rs1; ifc.rs2 = rs2; ifc.imm = imm;
            end else begin
                ifc.rd  = 5'($urandom);
                ifc.rs1 = 5'($urandom);
                ifc.rs2 = 5'($urandom);
                ifc.imm = $urandom;
            end
            send_char(m[39-8*i -: 8]);
        end
    endtask

    // Called at the negedge right after char 5 was accepted.
    task automatic expect_result(input string name, input logic exp_err, input logic [31:0] exp_instr);
        chk({name, "_latency"}, {31'd0, ifc.instr_valid}, 32'd0);
        @(negedge clock);
        if (exp_err) begin
            if (exp_cnt < 255) exp_cnt++;
            chk({name, "_err"}, {31'd0, err}, 32'd1);
            chk({name, "_novalid"}, {31'd0, ifc.instr_valid}, 32'd0);
            chk({name, "_errcnt"}, {24'd0, err_count}, 32'(exp_cnt));
            $display("txn %s err=%0d err_count=%0d", name, err, err_count);
            @(negedge clock);
            chk({name, "_errpulse"}, {31'd0, err}, 32'd0);
        end else begin
            chk({name, "_valid"}, {31'd0, ifc.instr_valid}, 32'd1);
            chk({name, "_instr"}, ifc.instr_out, exp_instr);
            $display("txn %s instr_out=%08h", name, ifc.instr_out);
            ifc.instr_ready = 1'b1;
            @(negedge clock);
            ifc.instr_ready = 1'b0;
            chk({name, "_drop"}, {31'd0, ifc.instr_valid}, 32'd0);
            chk({name, "_idle"}, {31'd0, ifc.char_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] held;
        ifc.char_in = 8'h0; ifc.char_valid = 1'b0; ifc.instr_ready = 1'b0;
        ifc.rd = '0; ifc.rs1 = '0; ifc.rs2 = '0; ifc.imm = '0;

        vecs[0]  = '{"ADD  ", 5'd3,  5'd1,  5'd2,  32'h0,        1'b0, 32'h002081B3};
        vecs[1]  = '{"SUB  ", 5'd5,  5'd6,  5'd7,  32'h0,        1'b0, 32'h407302B3};
        vecs[2]  = '{"SW   ", 5'd0,  5'd1,  5'd2,  32'h8,        1'b0, 32'h0020A423};
        vecs[3]  = '{"LUI  ", 5'd5,  5'd0,  5'd0,  32'h12345FFF, 1'b0, 32'h123452B7};
        vecs[4]  = '{"JAL  ", 5'd1,  5'd0,  5'd0,  32'h9,        1'b0, 32'h008000EF};
        vecs[5]  = '{"SRA  ", 5'd4,  5'd5,  5'd6,  32'h0,        1'b0, 32'h4062D233};
        vecs[6]  = '{"SLTU ", 5'd31, 5'd31, 5'd31, 32'h0,        1'b0, 32'h01FFBFB3};
        vecs[7]  = '{"SH   ", 5'd0,  5'd3,  5'd4,  32'h7FF,      1'b0, 32'h7E419FA3};
        vecs[8]  = '{"AUIPC", 5'd2,  5'd0,  5'd0,  32'hABCDE123, 1'b0, 32'hABCDE117};
        vecs[9]  = '{"JAL  ", 5'd0,  5'd0,  5'd0,  32'hFFFFFFFE, 1'b0, 32'hFFFFF06F};
        vecs[10] = '{"XOR  ", 5'd1,  5'd1,  5'd1,  32'h0,        1'b0, 32'h0010C0B3};
        vecs[11] = '{"FOO  ", 5'd1,  5'd1,  5'd1,  32'h0,        1'b1, 32'h0};
        vecs[12] = '{"ADD ",  5'd3,  5'd1,  5'd2,  32'h0,        1'b1, 32'h0};
`ifdef RSJU_LOWERCASE_EN
        vecs[13] = '{"add  ", 5'd3,  5'd1,  5'd2,  32'h0,        1'b0, 32'h002081B3};
`else
        vecs[13] = '{"add  ", 5'd3,  5'd1,  5'd2,  32'h0,        1'b1, 32'h0};
`endif

        repeat (3) @(negedge clock);
        chk("rst_char_ready", {31'd0, ifc.char_ready}, 32'd1);
        chk("rst_instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
        chk("rst_instr_out", ifc.instr_out, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 14; i++) begin
            send_mnem(vecs[i].mnem, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_instr);
        end

        // Backpressure: output held, no char accepted, then exactly one pending char taken after release.
        send_mnem("SUB  ", 5'd5, 5'd6, 5'd7, 32'h0);
        chk("stall_latency", {31'd0, ifc.instr_valid}, 32'd0);
        @(negedge clock);
        held = ifc.instr_out;
        chk("stall_first", held, 32'h407302B3);
        ifc.rd = 5'd1; ifc.rs1 = 5'd2; ifc.rs2 = 5'd3; ifc.imm = 32'h0;
        ifc.char_in = "O"; ifc.char_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk($sformatf("stall_hold%0d", c), ifc.instr_out, 32'h407302B3);
            chk($sformatf("stall_valid%0d", c), {31'd0, ifc.instr_valid}, 32'd1);
            chk($sformatf("stall_cready%0d", c), {31'd0, ifc.char_ready}, 32'd0);
        end
        ifc.instr_ready = 1'b1;
        @(negedge clock);
        ifc.instr_ready = 1'b0;
        chk("stall_release", {31'd0, ifc.instr_valid}, 32'd0);
        chk("stall_cready", {31'd0, ifc.char_ready}, 32'd1);
        @(negedge clock);
        ifc.char_valid = 1'b0;
        ifc.rd = 5'd9; ifc.rs1 = 5'd9; ifc.rs2 = 5'd9;
        send_char("R"); send_char(" "); send_char(" "); send_char(" ");
        expect_result("stall_or", 1'b0, 32'h003160B3);

        // Saturating counter.
        for (int k = 0; k < 260; k++) begin
            send_mnem("XYZ  ", 5'd0, 5'd0, 5'd0, 32'h0);
            expect_result($sformatf("bad%0d", k), 1'b1, 32'h0);
        end
        chk("sat_count", {24'd0, err_count}, 32'd255);

        // Asynchronous reset mid-mnemonic discards the partial characters.
        send_mnem("LUI  ", 5'd5, 5'd0, 5'd0, 32'h12345000);
        expect_result("pre_rst_lui", 1'b0, 32'h123452B7);
        ifc.rd = 5'd3; ifc.rs1 = 5'd1; ifc.rs2 = 5'd2;
        send_char("A"); send_char("D"); send_char("D");
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_char_ready", {31'd0, ifc.char_ready}, 32'd1);
        chk("mid_rst_instr_out", ifc.instr_out, 32'd0);
        chk("mid_rst_valid", {31'd0, ifc.instr_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        exp_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_mnem("OR   ", 5'd1, 5'd2, 5'd3, 32'h0);
        expect_result("post_rst_or", 1'b0, 32'h003160B3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
